reset_release_sequencer: RTL and testbench
==========================================

Name: reset_release_sequencer

Overview:
- Controller that brings a chain of delay-type blocks out of reset one at a time. Each block asserts `done` some clocks after its reset is released.
- Releases `stage_rst_out[i]` in index order, then waits for `stage_done_in[i]` before moving on. Enforces a programmable timeout per stage and a fixed inter-stage gap.
- Sits at top level between the board reset and every block that reports a `done`-after-delay status.

Parameters:
- NUM_STAGES, 4, number of sequenced downstream blocks (1..32).
- TMO_W, 8, width of the timeout counter and of `timeout_cycles`.
- GAP_CYCLES, 2, idle clocks between one stage's done being accepted and the next stage's release (0 allowed).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  1-cycle pulse; begins sequence, honoured only in IDLE.
- abort  input  1  1-cycle pulse; forces all stages back into reset, returns to IDLE.
- timeout_cycles  input  TMO_W  per-stage timeout; 0 = wait forever. Sampled at each stage release.
- stage_done_in  input  NUM_STAGES  done status from each downstream block.
- stage_rst_out  output  NUM_STAGES  active-high reset to each block.
- busy  output  1  sequence in progress.
- all_done  output  1  every stage released and done.
- error  output  1  a stage timed out.
- err_stage  output  IDX_W  index of timed-out stage; IDX_W = max(1, clog2(NUM_STAGES)).

Behaviour:
- All outputs registered.
- Reset values: stage_rst_out = all 1s; busy = 0; all_done = 0; error = 0; err_stage = 0; state = IDLE; idx = 0.
- Reset is honoured in any state; mid-sequence it re-asserts all stage resets immediately (async).
- States: IDLE, RELEASE, WAIT_DONE, GAP, COMPLETE, FAULT.
- IDLE
  - start=1 -> RELEASE, idx=0.
  - start and abort in the same cycle: abort wins, stay IDLE.
- RELEASE (1 clock)
  - On exit edge: stage_rst_out[idx] <= 0; timer <= timeout_cycles; -> WAIT_DONE.
  - Latency: start sampled at edge E0; stage_rst_out[0] low after edge E1.
- WAIT_DONE (samples only stage_done_in[idx]; other done bits ignored)
  - done=1:
    - idx == NUM_STAGES-1 -> COMPLETE.
    - Otherwise -> GAP, gap counter loaded with GAP_CYCLES.
    - If GAP_CYCLES=0 -> RELEASE directly with idx+1.
  - done=0, timeout_cycles≠0, timer=0 -> FAULT.
  - done=0, timer≠0 -> timer-1.
  - timeout_cycles=0: timer ignored, wait indefinitely.
  - Done already high at release is accepted at the first WAIT_DONE edge.
  - Done and timer expiry on the same edge: done wins.
  - A stage therefore gets timeout_cycles+1 sampling edges.
- GAP: counts GAP_CYCLES clocks, then idx <= idx+1 -> RELEASE.
- COMPLETE
  - all_done=1, busy=0, all stage_rst_out=0.
  - start ignored.
- FAULT
  - error=1, err_stage=idx, stage_rst_out[idx] re-asserted to 1.
  - Earlier stages stay released; busy=0; start ignored.
- busy=1 exactly in RELEASE, WAIT_DONE, GAP.
- abort in any non-IDLE state: next edge stage_rst_out = all 1s, all_done/error/err_stage cleared, idx=0, -> IDLE.
- stage_done_in deasserting after acceptance is ignored; no re-check.
- No wrap: idx never exceeds NUM_STAGES-1.

Test Plan:
- Nominal: NUM_STAGES=4, GAP_CYCLES=2, timeout=10, each done rises 3 clocks after its release.
  - Stage resets fall in order 0..3, release edges 6 clocks apart (1 release + 3 wait + 2 gap).
  - all_done=1 one edge after stage 3 done; busy low same edge; error=0.
- Timeout: timeout=5, stage 2 done held 0.
  - Exactly 6 WAIT_DONE edges after stage 2 release: error=1, err_stage=2, stage_rst_out=4'b1100, busy=0.
  - Later start pulses produce no change.
- Coincident: stage 1 done rises on the same edge the timer reaches 0 -> accepted; GAP entered; error stays 0.
- Ordering/early done: stage_done_in=4'b1000 from the start -> stage 3 not released early; stage 0 still gates progress.
  - Stage 3 done is accepted at its first WAIT_DONE edge.
- Abort/reset: abort during stage 1 WAIT_DONE -> next edge stage_rst_out=4'b1111, IDLE, busy=0.
  - Repeat the scenario with async rst mid-GAP -> outputs go to reset values without a clock edge.
  - Restart via start completes normally.
- Edge parameters: NUM_STAGES=1, GAP_CYCLES=0, timeout_cycles=0, done asserted after 300 clocks.
  - No error; all_done follows the done edge by 1 clock.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
// Brings a chain of downstream blocks out of reset one at a time, in index
// order. A stage is released, then its done flag is awaited (optionally under
// a timeout) before a fixed idle gap and the release of the next stage.
// All outputs come straight from flops.
module reset_release_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int TMO_W      = 8,
    parameter int GAP_CYCLES = 2,
    localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TMO_W-1:0]      timeout_cycles,
    input  logic [NUM_STAGES-1:0] stage_done_in,
    output logic [NUM_STAGES-1:0] stage_rst_out,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_stage
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_WAIT_DONE,
        S_GAP,
        S_COMPLETE,
        S_FAULT
    } state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [TMO_W-1:0]        timer_reg, timer_next;
    logic                    tmo_en_reg, tmo_en_next;
    logic [GAP_W-1:0]        gap_reg, gap_next;
    logic [NUM_STAGES-1:0]   stage_rst_reg, stage_rst_next;
    logic                    busy_reg, busy_next;
    logic                    all_done_reg, all_done_next;
    logic                    error_reg, error_next;
    logic [IDX_W-1:0]        err_stage_reg, err_stage_next;

    // One-hot decode of the current stage index; used both to pick the
    // done bit being awaited and to clear/set that stage's reset bit.
    logic [NUM_STAGES-1:0]   idx_onehot;
    logic                    done_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_idx_sel
            assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign done_sel = |(stage_done_in & idx_onehot);

    // State and registered-output flops; reset puts every stage back in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            timer_reg     <= '0;
            tmo_en_reg    <= 1'b0;
            gap_reg       <= '0;
            stage_rst_reg <= '1;
            busy_reg      <= 1'b0;
            all_done_reg  <= 1'b0;
            error_reg     <= 1'b0;
            err_stage_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            tmo_en_reg    <= tmo_en_next;
            gap_reg       <= gap_next;
            stage_rst_reg <= stage_rst_next;
            busy_reg      <= busy_next;
            all_done_reg  <= all_done_next;
            error_reg     <= error_next;
            err_stage_reg <= err_stage_next;
        end
    end

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        timer_next     = timer_reg;
        tmo_en_next    = tmo_en_reg;
        gap_next       = gap_reg;
        stage_rst_next = stage_rst_reg;
        all_done_next  = all_done_reg;
        error_next     = error_reg;
        err_stage_next = err_stage_reg;

        if (abort) begin
            state_next     = S_IDLE;
            idx_next       = '0;
            timer_next     = '0;
            tmo_en_next    = 1'b0;
            gap_next       = '0;
            stage_rst_next = '1;
            all_done_next  = 1'b0;
            error_next     = 1'b0;
            err_stage_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RELEASE;
                        idx_next   = '0;
                    end
                end
                S_RELEASE: begin
                    // Timeout is captured here so a change mid-wait has no effect.
                    stage_rst_next = stage_rst_reg & ~idx_onehot;
                    timer_next     = timeout_cycles;
                    tmo_en_next    = |timeout_cycles;
                    state_next     = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // Done is checked before the timer, so a done arriving on
                    // the expiry edge is still accepted.
                    if (done_sel) begin
                        if (idx_reg == LAST_IDX) begin
                            state_next    = S_COMPLETE;
                            all_done_next = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_next = S_RELEASE;
                            idx_next   = idx_reg + IDX_W'(1);
                        end else begin
                            state_next = S_GAP;
                            gap_next   = GAP_LOAD;
                        end
                    end else if (tmo_en_reg && (timer_reg == '0)) begin
                        state_next     = S_FAULT;
                        error_next     = 1'b1;
                        err_stage_next = idx_reg;
                        stage_rst_next = stage_rst_reg | idx_onehot;
                    end else if (timer_reg != '0) begin
                        timer_next = timer_reg - TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_reg <= GAP_W'(1)) begin
                        state_next = S_RELEASE;
                        idx_next   = idx_reg + IDX_W'(1);
                    end else begin
                        gap_next = gap_reg - GAP_W'(1);
                    end
                end
                S_COMPLETE: begin
                    state_next = S_COMPLETE;
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        busy_next = (state_next == S_RELEASE) || (state_next == S_WAIT_DONE) ||
                    (state_next == S_GAP);
    end

    assign stage_rst_out = stage_rst_reg;
    assign busy          = busy_reg;
    assign all_done      = all_done_reg;
    assign error         = error_reg;
    assign err_stage     = err_stage_reg;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Testbench for reset_release_sequencer: a table-driven nominal run on a
// 4-stage instance, hand-written corner sequences, and a 1-stage /
// zero-gap / no-timeout instance.
module tb_reset_release_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] timeout_cycles;
    logic [3:0] stage_done_in;
    logic [3:0] stage_rst_out;
    logic       busy;
    logic       all_done;
    logic       error;
    logic [1:0] err_stage;

    logic       start1;
    logic       abort1;
    logic [7:0] timeout1;
    logic [0:0] done1;
    logic [0:0] rst_out1;
    logic       busy1;
    logic       all_done1;
    logic       error1;
    logic [0:0] err_stage1;

    int n_checks = 0;
    int n_errors = 0;

    reset_release_sequencer #(
        .NUM_STAGES (4),
        .TMO_W      (8),
        .GAP_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .timeout_cycles (timeout_cycles),
        .stage_done_in  (stage_done_in),
        .stage_rst_out  (stage_rst_out),
        .busy           (busy),
        .all_done       (all_done),
        .error          (error),
        .err_stage      (err_stage)
    );

    reset_release_sequencer #(
        .NUM_STAGES (1),
        .TMO_W      (8),
        .GAP_CYCLES (0)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .start          (start1),
        .abort          (abort1),
        .timeout_cycles (timeout1),
        .stage_done_in  (done1),
        .stage_rst_out  (rst_out1),
        .busy           (busy1),
        .all_done       (all_done1),
        .error          (error1),
        .err_stage      (err_stage1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] o0;
    logic [15:0] o1;
    assign o0 = {7'd0, stage_rst_out, busy, all_done, error, err_stage};
    assign o1 = {11'd0, rst_out1, busy1, all_done1, error1, err_stage1};

    function automatic logic [15:0] exp0(input logic [3:0] r, input logic b,
                                         input logic ad, input logic er,
                                         input logic [1:0] es);
        return {7'd0, r, b, ad, er, es};
    endfunction

    function automatic logic [15:0] exp1(input logic r, input logic b,
                                         input logic ad, input logic er);
        return {11'd0, r, b, ad, er, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // Present new done bits, ride through accept + 2 gap edges + release edge.
    task automatic advance_stage(input logic [3:0] d, input logic [3:0] r,
                                 input string name);
        stage_done_in = d;
        repeat (4) tick();
        check(name, o0, exp0(r, 1'b1, 1'b0, 1'b0, 2'd0));
    endtask

    typedef struct {
        logic       start;
        logic [3:0] done;
        logic [3:0] e_rst;
        logic       e_busy;
        logic       e_all_done;
    } vec_t;

    vec_t tbl [24];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal run: done for stage i rises on the 3rd WAIT_DONE edge.
        tbl[0]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 4'hE, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 4'hE, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 4'hE, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'h1, 4'hE, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'h1, 4'hC, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'h1, 4'hC, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'h1, 4'hC, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'h3, 4'hC, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h3, 4'hC, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'h3, 4'hC, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'h3, 4'h8, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'h3, 4'h8, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'h3, 4'h8, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'h7, 4'h8, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 4'h7, 4'h8, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'h7, 4'h8, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 4'h7, 4'h0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'h7, 4'h0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'h7, 4'h0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[23] = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        timeout_cycles = 8'd0;
        stage_done_in = 4'h0;
        start1 = 1'b0;
        abort1 = 1'b0;
        timeout1 = 8'd0;
        done1 = 1'b0;

        repeat (2) tick();
        check("reset_values", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        check("reset_values_1stage", o1, exp1(1'b1, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        tick();
        check("idle_hold", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        tick();
        check("start_abort_idle2", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));

        // nominal table
        timeout_cycles = 8'd10;
        for (int k = 0; k < 24; k++) begin
            start = tbl[k].start;
            stage_done_in = tbl[k].done;
            tick();
            check($sformatf("nominal[%0d]", k), o0,
                  exp0(tbl[k].e_rst, tbl[k].e_busy, tbl[k].e_all_done, 1'b0, 2'd0));
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_complete", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));

        // timeout on stage 2: 6 WAIT_DONE edges with timeout 5
        timeout_cycles = 8'd5;
        stage_done_in = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("tmo_release2", o0, exp0(4'h8, 1'b1, 1'b0, 1'b0, 2'd0));
        repeat (5) tick();
        check("tmo_edge5_no_fault", o0, exp0(4'h8, 1'b1, 1'b0, 1'b0, 2'd0));
        tick();
        check("tmo_fault", o0, exp0(4'hC, 1'b0, 1'b0, 1'b1, 2'd2));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("tmo_start_ignored", o0, exp0(4'hC, 1'b0, 1'b0, 1'b1, 2'd2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_fault", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));

        // early done on stage 3 must not skip ahead; stage 0 gates progress
        timeout_cycles = 8'd0;
        stage_done_in = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("early_release0", o0, exp0(4'hE, 1'b1, 1'b0, 1'b0, 2'd0));
        repeat (10) tick();
        check("early_gated", o0, exp0(4'hE, 1'b1, 1'b0, 1'b0, 2'd0));
        advance_stage(4'b1001, 4'hC, "early_release1");
        advance_stage(4'b1011, 4'h8, "early_release2");
        advance_stage(4'b1111, 4'h0, "early_release3");
        tick();
        check("early_s3_first_wait", o0, exp0(4'h0, 1'b0, 1'b1, 1'b0, 2'd0));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // stage 1 done arrives on the timer-expiry edge: done wins
        timeout_cycles = 8'd3;
        stage_done_in = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("coin_release1", o0, exp0(4'hC, 1'b1, 1'b0, 1'b0, 2'd0));
        repeat (3) tick();
        stage_done_in = 4'b0011;
        tick();
        check("coin_accept", o0, exp0(4'hC, 1'b1, 1'b0, 1'b0, 2'd0));
        repeat (3) tick();
        check("coin_release2", o0, exp0(4'h8, 1'b1, 1'b0, 1'b0, 2'd0));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort while waiting on stage 1
        timeout_cycles = 8'd0;
        stage_done_in = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("abort_pre", o0, exp0(4'hC, 1'b1, 1'b0, 1'b0, 2'd0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait_done", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        tick();
        check("abort_stays_idle", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));

        // asynchronous reset while in GAP
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("gap_pre", o0, exp0(4'hE, 1'b1, 1'b0, 1'b0, 2'd0));
        #1 rst = 1'b1;
        #1 check("async_rst_gap", o0, exp0(4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        @(negedge clk);
        rst = 1'b0;

        // restart after reset completes normally
        stage_done_in = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        check("restart_release3", o0, exp0(4'h0, 1'b1, 1'b0, 1'b0, 2'd0));
        tick();
        check("restart_complete", o0, exp0(4'h0, 1'b0, 1'b1, 1'b0, 2'd0));

        // single stage, no gap, wait forever
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("one_released", o1, exp1(1'b0, 1'b1, 1'b0, 1'b0));
        repeat (299) tick();
        check("one_long_wait", o1, exp1(1'b0, 1'b1, 1'b0, 1'b0));
        done1 = 1'b1;
        tick();
        check("one_all_done", o1, exp1(1'b0, 1'b0, 1'b1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
